// File: rtl/resource_lock_client.sv
`default_nettype none
// ============================================================================
// Module   : resource_lock_client
// Purpose  : Per-port requester for the resource pool lock. Accepts a tagged
//            job, raises req until granted, holds the granted resource for
//            a programmed number of cycles, then releases it and reports
//            completion.
// Revision : 1.0 - initial release
// ============================================================================
module resource_lock_client #(
    parameter int ID_WIDTH     = 8,
    parameter int RES_ID_WIDTH = 2,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [ID_WIDTH-1:0]     job_issue_id,
    input  logic [CNT_WIDTH-1:0]    job_hold_cycles,
    input  logic                    flush,
    output logic                    req,
    output logic [ID_WIDTH-1:0]     req_issue_id,
    output logic                    release_lock,
    input  logic                    grant,
    input  logic [RES_ID_WIDTH-1:0] alloc_id,
    output logic                    use_valid,
    output logic [RES_ID_WIDTH-1:0] use_res_id,
    output logic [ID_WIDTH-1:0]     use_issue_id,
    output logic                    done,
    output logic                    done_flushed,
    output logic [ID_WIDTH-1:0]     done_issue_id,
    output logic [RES_ID_WIDTH-1:0] done_res_id,
    output logic [7:0]              wait_cycles,
    output logic                    lost_grant
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_hold = 2'd2;
    localparam logic [1:0] c_st_rel  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [7:0]           c_wcnt_max = 8'hFF;

    logic [1:0]              r_state;
    logic [ID_WIDTH-1:0]     r_id;
    logic [RES_ID_WIDTH-1:0] r_res;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [7:0]              r_wcnt;
    logic [7:0]              r_wait;
    logic                    r_flushed;
    logic                    r_lost;

    logic                    w_live;
    logic                    w_idle;
    logic                    w_req_st;
    logic                    w_hold_st;
    logic                    w_rel_st;
    logic                    w_accept;
    logic [CNT_WIDTH-1:0]    w_hold_eff;

    // Every output is forced low while reset is asserted, so the pool never
    // sees a stale req/release from a state that is about to be cleared.
    assign w_live    = !rst;
    assign w_idle    = (r_state == c_st_idle);
    assign w_req_st  = (r_state == c_st_req);
    assign w_hold_st = (r_state == c_st_hold);
    assign w_rel_st  = (r_state == c_st_rel);

    // A zero hold count still occupies the resource for one cycle.
    assign w_hold_eff = (job_hold_cycles == '0) ? c_cnt_one : job_hold_cycles;

    // A flushed job completing in REL must not chain straight into a new job.
    assign job_ready = w_live && !flush && (w_idle || (w_rel_st && !r_flushed));
    assign w_accept  = job_valid && job_ready;

    // req drops in the flush cycle itself so no grant can be taken then.
    assign req          = w_live && w_req_st && !flush;
    assign req_issue_id = (w_live && w_req_st) ? r_id : '0;

    assign use_valid    = w_live && w_hold_st;
    assign use_res_id   = use_valid ? r_res : '0;
    assign use_issue_id = use_valid ? r_id : '0;

    assign release_lock  = w_live && w_rel_st;
    assign done          = release_lock;
    assign done_flushed  = release_lock && r_flushed;
    assign done_issue_id = release_lock ? r_id : '0;
    assign done_res_id   = release_lock ? r_res : '0;

    assign wait_cycles = w_live ? r_wait : 8'd0;
    assign lost_grant  = w_live && r_lost;

    // Protocol sequencer: IDLE -> REQ -> HOLD -> REL, with REL able to
    // accept the next job directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_id      <= '0;
            r_res     <= '0;
            r_cnt     <= '0;
            r_wcnt    <= '0;
            r_wait    <= '0;
            r_flushed <= 1'b0;
            r_lost    <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_id    <= job_issue_id;
                        r_cnt   <= w_hold_eff;
                        r_wcnt  <= '0;
                        r_state <= c_st_req;
                    end
                end
                c_st_req: begin
                    if (flush) begin
                        r_state <= c_st_idle;
                    end else if (grant) begin
                        r_res   <= alloc_id;
                        r_wait  <= r_wcnt;
                        r_state <= c_st_hold;
                    end else if (r_wcnt != c_wcnt_max) begin
                        r_wcnt <= r_wcnt + 8'd1;
                    end
                end
                c_st_hold: begin
                    if (!grant) begin
                        r_lost <= 1'b1;
                    end
                    r_cnt <= r_cnt - c_cnt_one;
                    if ((r_cnt == c_cnt_one) || flush) begin
                        r_flushed <= flush;
                        r_state   <= c_st_rel;
                    end
                end
                c_st_rel: begin
                    if (w_accept) begin
                        r_id    <= job_issue_id;
                        r_cnt   <= w_hold_eff;
                        r_wcnt  <= '0;
                        r_state <= c_st_req;
                    end else begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire
